// File: rtl/cle_sram_arbiter.sv
// cle_sram_arbiter: shares the single-port label SRAM between the CLE
// labeling engine (port 0) and the relabel/readout engine (port 1).
// Grants are combinational with a burst-limited round-robin policy, and
// 1-cycle-latency read data is steered back to the port that issued it.
module cle_sram_arbiter #(
  parameter int AW        = 10,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_d,
  output logic          sram_wen,
  input  logic [DW-1:0] sram_q
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

  logic          owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          r0_rvalid_q, r0_rvalid_d;
  logic          r1_rvalid_q, r1_rvalid_d;
  logic          gnt0, gnt1;

  // Grant decision; forced low while in reset so gnt drops immediately.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset) begin
      if (r0_req && r1_req) begin
        if (cnt_q < CNT_MAX) begin
          gnt0 = ~owner_q;
          gnt1 = owner_q;
        end else begin
          gnt0 = owner_q;
          gnt1 = ~owner_q;
        end
      end else begin
        gnt0 = r0_req;
        gnt1 = r1_req;
      end
    end
  end

  // Owner/burst bookkeeping: saturating count, reset to zero by an idle cycle.
  always_comb begin
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (gnt0 || gnt1) begin
      if (gnt1 == owner_q) begin
        cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);
      end else begin
        owner_d = gnt1;
        cnt_d   = CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Read-valid tags follow the granted read by exactly one cycle.
  always_comb begin
    r0_rvalid_d = gnt0 & ~r0_we;
    r1_rvalid_d = gnt1 & ~r1_we;
  end

  // SRAM drive mux; parks the bus at zero with writes disabled when idle.
  always_comb begin
    sram_wen = 1'b1;
    sram_a   = '0;
    sram_d   = '0;
    if (gnt0) begin
      sram_wen = ~r0_we;
      sram_a   = r0_addr;
      sram_d   = r0_wdata;
    end else if (gnt1) begin
      sram_wen = ~r1_we;
      sram_a   = r1_addr;
      sram_d   = r1_wdata;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      r0_rvalid_q <= r0_rvalid_d;
      r1_rvalid_q <= r1_rvalid_d;
    end
  end

  assign r0_gnt    = gnt0;
  assign r1_gnt    = gnt1;
  assign r0_rvalid = r0_rvalid_q;
  assign r1_rvalid = r1_rvalid_q;
  assign r0_rdata  = sram_q;
  assign r1_rdata  = sram_q;

endmodule

// File: tb/tb_cle_sram_arbiter.sv
// Directed testbench for cle_sram_arbiter with a behavioural SRAM and a
// per-port read-data scoreboard.
module tb_cle_sram_arbiter;

  logic       clk;
  logic       reset;
  logic       r0_req, r0_we, r1_req, r1_we;
  logic [9:0] r0_addr, r1_addr;
  logic [7:0] r0_wdata, r1_wdata;
  logic       r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [7:0] r0_rdata, r1_rdata;
  logic [9:0] sram_a;
  logic [7:0] sram_d;
  logic       sram_wen;
  logic [7:0] sram_q;

  logic [7:0] memArray [0:1023];
  logic [7:0] expQ0 [$];
  logic [7:0] expQ1 [$];
  int         vectorCount;
  int         miscompareCount;

  cle_sram_arbiter #(.AW(10), .DW(8), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .sram_a(sram_a), .sram_d(sram_d), .sram_wen(sram_wen), .sram_q(sram_q)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural single-port SRAM: one-cycle read latency, CEN always active.
  always @(posedge clk) begin
    if (!sram_wen) memArray[sram_a] <= sram_d;
    sram_q <= memArray[sram_a];
  end

  // One comparison: counts it and reports a miscompare with tag and values.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    assert (observed === expected) else begin
      miscompareCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives both requester ports at once.
  task automatic applyStimulus(input logic q0, input logic w0, input logic [9:0] a0,
                               input logic [7:0] d0, input logic q1, input logic w1,
                               input logic [9:0] a1, input logic [7:0] d1);
    r0_req = q0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
    r1_req = q1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
  endtask

  // Moves inputs just past the next rising edge.
  task automatic nextEdge();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every rvalid pops the oldest expected read data for that port.
  always @(negedge clk) begin
    if (r0_rvalid === 1'b1) begin
      if (expQ0.size() == 0) checkOutput("r0_rvalid_spurious", 32'd1, 32'd0);
      else checkOutput("r0_rdata", {24'd0, r0_rdata}, {24'd0, expQ0.pop_front()});
    end
    if (r1_rvalid === 1'b1) begin
      if (expQ1.size() == 0) checkOutput("r1_rvalid_spurious", 32'd1, 32'd0);
      else checkOutput("r1_rdata", {24'd0, r1_rdata}, {24'd0, expQ1.pop_front()});
    end
  end

  // Directed sequence: reset, contention, write/read, cross-port order, idle, reset.
  initial begin
    logic exp1;
    vectorCount = 0;
    miscompareCount = 0;

    // Reset held with both ports requesting: nothing may be granted.
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 10'h155, 8'h11, 1'b1, 1'b1, 10'h2AA, 8'h22);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("t1_r0_gnt", r0_gnt, 0);
    checkOutput("t1_r1_gnt", r1_gnt, 0);
    checkOutput("t1_r0_rvalid", r0_rvalid, 0);
    checkOutput("t1_r1_rvalid", r1_rvalid, 0);
    checkOutput("t1_sram_wen", sram_wen, 1);
    checkOutput("t1_sram_a", sram_a, 0);
    checkOutput("t1_sram_d", sram_d, 0);
    nextEdge();
    reset = 1'b1;

    // Continuous contention from reset: 0,0,0,0,1,1,1,1,0.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      exp1 = (i >= 4 && i < 8);
      checkOutput("t3_r0_gnt", r0_gnt, !exp1);
      checkOutput("t3_r1_gnt", r1_gnt, exp1);
      checkOutput("t3_single_gnt", r0_gnt & r1_gnt, 0);
      nextEdge();
    end

    // Idle cycle parks the SRAM bus.
    applyStimulus(1'b0, 1'b0, 10'h3FF, 8'hFF, 1'b0, 1'b0, 10'h3FF, 8'hFF);
    @(negedge clk);
    checkOutput("idle_gnt", {r0_gnt, r1_gnt}, 0);
    checkOutput("idle_wen", sram_wen, 1);
    checkOutput("idle_a", sram_a, 0);
    nextEdge();

    // Port 0 writes 0x3FF then reads it back the next cycle.
    applyStimulus(1'b1, 1'b1, 10'h3FF, 8'hA5, 1'b0, 1'b0, 10'h0, 8'h0);
    @(negedge clk);
    checkOutput("t2_wr_gnt", r0_gnt, 1);
    checkOutput("t2_wr_r1_gnt", r1_gnt, 0);
    checkOutput("t2_wr_wen", sram_wen, 0);
    checkOutput("t2_wr_a", sram_a, 10'h3FF);
    checkOutput("t2_wr_d", sram_d, 8'hA5);
    nextEdge();
    applyStimulus(1'b1, 1'b0, 10'h3FF, 8'h00, 1'b0, 1'b0, 10'h0, 8'h0);
    @(negedge clk);
    checkOutput("t2_rd_gnt", r0_gnt, 1);
    checkOutput("t2_rd_wen", sram_wen, 1);
    expQ0.push_back(8'hA5);
    nextEdge();
    applyStimulus(1'b0, 1'b0, 10'h0, 8'h0, 1'b0, 1'b0, 10'h0, 8'h0);
    @(negedge clk);
    checkOutput("t2_rvalid", r0_rvalid, 1);
    nextEdge();

    // Cross-port ordering on address 0x010.
    applyStimulus(1'b1, 1'b1, 10'h010, 8'h03, 1'b0, 1'b0, 10'h0, 8'h0);
    @(negedge clk);
    checkOutput("t4_seed_gnt", r0_gnt, 1);
    nextEdge();
    applyStimulus(1'b1, 1'b0, 10'h010, 8'h00, 1'b1, 1'b1, 10'h010, 8'h07);
    @(negedge clk);
    checkOutput("t4_rd_r0_gnt", r0_gnt, 1);
    checkOutput("t4_rd_r1_gnt", r1_gnt, 0);
    expQ0.push_back(8'h03);
    nextEdge();
    applyStimulus(1'b0, 1'b0, 10'h000, 8'h00, 1'b1, 1'b1, 10'h010, 8'h07);
    @(negedge clk);
    checkOutput("t4_wr_r1_gnt", r1_gnt, 1);
    checkOutput("t4_wr_wen", sram_wen, 0);
    checkOutput("t4_wr_d", sram_d, 8'h07);
    nextEdge();
    applyStimulus(1'b1, 1'b0, 10'h010, 8'h00, 1'b0, 1'b0, 10'h0, 8'h0);
    @(negedge clk);
    checkOutput("t4_rd2_r0_gnt", r0_gnt, 1);
    expQ0.push_back(8'h07);
    nextEdge();
    applyStimulus(1'b0, 1'b0, 10'h0, 8'h0, 1'b0, 1'b0, 10'h0, 8'h0);
    nextEdge();

    // Idle cycle ends a burst: 3 solo grants, idle, then a full burst of 4.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 10'h020 + 10'(i), 8'h40, 1'b0, 1'b0, 10'h0, 8'h0);
      @(negedge clk);
      checkOutput("t5_solo_gnt", r0_gnt, 1);
      nextEdge();
    end
    applyStimulus(1'b0, 1'b0, 10'h0, 8'h0, 1'b0, 1'b0, 10'h0, 8'h0);
    @(negedge clk);
    checkOutput("t5_idle_gnt", {r0_gnt, r1_gnt}, 0);
    nextEdge();
    applyStimulus(1'b1, 1'b1, 10'h030, 8'h50, 1'b1, 1'b1, 10'h031, 8'h51);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t5_r0_gnt", r0_gnt, (i < 4));
      checkOutput("t5_r1_gnt", r1_gnt, (i == 4));
      nextEdge();
    end

    // Reset kills an in-flight port-1 read, then port 0 wins first.
    applyStimulus(1'b0, 1'b0, 10'h0, 8'h0, 1'b1, 1'b0, 10'h010, 8'h00);
    @(negedge clk);
    checkOutput("t6_r1_gnt", r1_gnt, 1);
    nextEdge();
    checkOutput("t6_rvalid_inflight", r1_rvalid, 1);
    #1 reset = 1'b0;
    #1;
    checkOutput("t6_rvalid_drop", r1_rvalid, 0);
    checkOutput("t6_gnt_drop", r1_gnt, 0);
    checkOutput("t6_wen_reset", sram_wen, 1);
    applyStimulus(1'b1, 1'b1, 10'h040, 8'h60, 1'b1, 1'b1, 10'h041, 8'h61);
    @(negedge clk);
    checkOutput("t6_rvalid_held", r1_rvalid, 0);
    nextEdge();
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t6_post_r0_gnt", r0_gnt, 1);
    checkOutput("t6_post_r1_gnt", r1_gnt, 0);
    nextEdge();
    applyStimulus(1'b0, 1'b0, 10'h0, 8'h0, 1'b0, 1'b0, 10'h0, 8'h0);
    repeat (2) nextEdge();
    checkOutput("r0_queue_drained", expQ0.size(), 0);
    checkOutput("r1_queue_drained", expQ1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
